// File: rtl/fsm_sched_pkg.sv
// Shared types for the round-robin handshake scheduler: FSM states, engine
// phase codes and the bundle of registered engine drive bits.
package fsm_sched_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LAUNCH  = 3'd1,
    CONFIRM = 3'd2,
    HOLD    = 3'd3,
    RELEASE = 3'd4
  } sched_st_e;

  localparam logic [2:0] ENG_IDLE = 3'b000;
  localparam logic [2:0] ENG_S1   = 3'b100;
  localparam logic [2:0] ENG_S2   = 3'b110;
  localparam logic [2:0] ENG_S3   = 3'b111;

  typedef struct packed {
    logic in1;
    logic in2;
    logic in3;
  } eng_drv_t;

endpackage

// File: rtl/fsm_rr_scheduler_rr_pick.sv
// Combinational round-robin picker: first set req bit scanning upward from
// last+1, wrapping modulo N_REQ.
module rr_pick #(
  parameter int N_REQ = 4,
  parameter int LW    = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [LW-1:0]    last,
  output logic [N_REQ-1:0] pick_oh,
  output logic [LW-1:0]    pick_idx
);

  logic          found;
  int            j;
  logic [LW-1:0] cand;

  always_comb begin
    found    = 1'b0;
    pick_idx = '0;
    j        = 0;
    cand     = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      j    = (int'(last) + i) % N_REQ;
      cand = LW'(j);
      if (!found && req[cand]) begin
        found    = 1'b1;
        pick_idx = cand;
      end
    end
    pick_oh = N_REQ'(found) << pick_idx;
  end

endmodule

// File: rtl/fsm_rr_scheduler.sv
// Shares one four-phase handshake engine among N_REQ requesters: round-robin
// grant, phase walk, HOLD occupancy limit and engine stall recovery.
module fsm_rr_scheduler
  import fsm_sched_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] done,
  input  logic [2:0]       eng_st,
  output logic [N_REQ-1:0] grant,
  output logic             eng_in1,
  output logic             eng_in2,
  output logic             eng_in3,
  output logic             busy,
  output logic             tmo_err,
  output logic             eng_err
);

  localparam int LW = $clog2(N_REQ);
  localparam int TW = $clog2(TIMEOUT);
  localparam logic [TW-1:0] T_LAST   = TW'(TIMEOUT - 1);
  localparam logic [LW-1:0] LAST_RST = LW'(N_REQ - 1);

  sched_st_e        state_q, state_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic [LW-1:0]    last_q, last_d;
  logic [LW-1:0]    g_q, g_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  eng_drv_t         drv_q, drv_d;
  logic             busy_q, busy_d;
  logic             tmo_err_q, tmo_err_d;
  logic             eng_err_q, eng_err_d;

  logic [N_REQ-1:0] pick_oh;
  logic [LW-1:0]    pick_idx;
  logic             expired;
  logic             abort;

  rr_pick #(.N_REQ(N_REQ)) u_pick (
    .req      (req),
    .last     (last_q),
    .pick_oh  (pick_oh),
    .pick_idx (pick_idx)
  );

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    g_d       = g_q;
    grant_d   = grant_q;
    drv_d     = drv_q;
    tmo_err_d = 1'b0;
    eng_err_d = 1'b0;
    abort     = 1'b0;
    expired   = (timer_q == T_LAST);

    case (state_q)
      IDLE: begin
        if (|req && eng_st == ENG_IDLE) begin
          grant_d   = pick_oh;
          drv_d.in1 = 1'b1;
          g_d       = pick_idx;
          state_d   = LAUNCH;
        end
      end
      LAUNCH: begin
        // A requester that dropped req here still sees the engine reach S1;
        // continue goes out low and the engine falls back to idle in CONFIRM.
        if (eng_st == ENG_S1) begin
          drv_d.in1 = 1'b0;
          drv_d.in2 = req[g_q];
          state_d   = CONFIRM;
        end else if (expired) begin
          abort = 1'b1;
        end
      end
      CONFIRM: begin
        if (eng_st == ENG_S3) begin
          drv_d.in2 = 1'b0;
          state_d   = HOLD;
        end else if (eng_st == ENG_IDLE) begin
          drv_d.in2 = 1'b0;
          grant_d   = '0;
          last_d    = g_q;
          state_d   = IDLE;
        end else if (expired) begin
          abort = 1'b1;
        end
      end
      HOLD: begin
        if (done[g_q]) begin
          drv_d.in3 = 1'b1;
          state_d   = RELEASE;
        end else if (expired) begin
          drv_d.in3 = 1'b1;
          tmo_err_d = 1'b1;
          state_d   = RELEASE;
        end
      end
      RELEASE: begin
        if (eng_st == ENG_IDLE) begin
          drv_d.in3 = 1'b0;
          grant_d   = '0;
          last_d    = g_q;
          state_d   = IDLE;
        end else if (expired) begin
          abort = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (abort) begin
      drv_d     = '0;
      grant_d   = '0;
      eng_err_d = 1'b1;
      last_d    = g_q;
      state_d   = IDLE;
    end

    timer_d = (state_d != state_q) ? '0 : timer_q + 1'b1;
    busy_d  = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      timer_q   <= '0;
      last_q    <= LAST_RST;
      g_q       <= '0;
      grant_q   <= '0;
      drv_q     <= '0;
      busy_q    <= 1'b0;
      tmo_err_q <= 1'b0;
      eng_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      last_q    <= last_d;
      g_q       <= g_d;
      grant_q   <= grant_d;
      drv_q     <= drv_d;
      busy_q    <= busy_d;
      tmo_err_q <= tmo_err_d;
      eng_err_q <= eng_err_d;
    end
  end

  assign grant   = grant_q;
  assign eng_in1 = drv_q.in1;
  assign eng_in2 = drv_q.in2;
  assign eng_in3 = drv_q.in3;
  assign busy    = busy_q;
  assign tmo_err = tmo_err_q;
  assign eng_err = eng_err_q;

endmodule

// File: tb/tb_fsm_rr_scheduler.sv
// Directed bench for fsm_rr_scheduler with a small four-phase engine model
// that follows the registered eng_in* drives.
module tb_fsm_rr_scheduler;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req, done, grant;
  logic [2:0] eng_st;
  logic       eng_in1, eng_in2, eng_in3, busy, tmo_err, eng_err;
  logic       stall, via110;
  int         n_chk = 0;
  int         n_fail = 0;
  bit         ok;
  logic [3:0] rr_exp [5];

  always #5 clk = ~clk;

  fsm_rr_scheduler #(.N_REQ(4), .TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .done(done), .eng_st(eng_st),
    .grant(grant), .eng_in1(eng_in1), .eng_in2(eng_in2), .eng_in3(eng_in3),
    .busy(busy), .tmo_err(tmo_err), .eng_err(eng_err)
  );

  // Engine: start -> S1, continue -> S3 (optionally via S2), release -> idle.
  // S1 with both start and continue low means the requester withdrew.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) eng_st <= 3'b000;
    else if (!stall) begin
      case (eng_st)
        3'b000: if (eng_in1) eng_st <= 3'b100;
        3'b100: if (eng_in2) eng_st <= via110 ? 3'b110 : 3'b111;
                else if (!eng_in1) eng_st <= 3'b000;
        3'b110: eng_st <= 3'b111;
        3'b111: if (eng_in3) eng_st <= 3'b000;
        default: eng_st <= 3'b000;
      endcase
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_hold(output bit hit);
    hit = 1'b0;
    for (int c = 0; c < 40 && !hit; c++) begin
      tick();
      if (eng_st == 3'b111 && grant != 4'b0 && !eng_in2 && !eng_in3) hit = 1'b1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
    $fatal(1);
  end

  initial begin
    rr_exp[0] = 4'b0001; rr_exp[1] = 4'b0010; rr_exp[2] = 4'b0100;
    rr_exp[3] = 4'b1000; rr_exp[4] = 4'b0001;
    rst_n = 1'b0; req = '0; done = '0; stall = 1'b0; via110 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_grant", grant, 0);
    chk("rst_drv", {eng_in1, eng_in2, eng_in3}, 0);
    chk("rst_busy", busy, 0);
    chk("rst_errs", {tmo_err, eng_err}, 0);
    rst_n = 1'b1;
    tick();

    // Round-robin with all four requesting; engine passes through 110.
    req = 4'b1111; via110 = 1'b1;
    for (int n = 0; n < 5; n++) begin
      wait_hold(ok);
      chk("rr_hold", ok, 1);
      chk("rr_grant", grant, rr_exp[n]);
      if (n == 0) begin
        done = ~rr_exp[n];
        tick();
        done = '0;
        chk("rr_foreign_done", eng_in3, 0);
      end
      done = rr_exp[n];
      if (n == 4) req = '0;
      tick();
      done = '0;
      chk("rr_in3", eng_in3, 1);
      tick();
      chk("rr_still_granted", grant, rr_exp[n]);
      tick();
      chk("rr_released", grant, 0);
      if (n < 4) begin
        tick();
        chk("rr_next", grant, rr_exp[n+1]);
      end
    end
    via110 = 1'b0;

    // Single requester, edge-by-edge phase walk.
    req = 4'b0001;
    tick(); chk("s_grant", grant, 4'b0001); chk("s_in1", eng_in1, 1); chk("s_busy", busy, 1);
    tick(); chk("s_eng100", eng_st, 3'b100);
    tick(); chk("s_in12", {eng_in1, eng_in2}, 2'b01);
    tick(); chk("s_eng111", eng_st, 3'b111); chk("s_in2_conf", eng_in2, 1);
    tick(); chk("s_hold_in2", eng_in2, 0); chk("s_hold_grant", grant, 4'b0001);
    tick();
    done = 4'b0001; req = '0;
    tick(); done = '0; chk("s_in3", eng_in3, 1);
    tick(); chk("s_eng000", eng_st, 3'b000); chk("s_grant_k1", grant, 4'b0001);
    tick(); chk("s_rel_grant", grant, 0); chk("s_rel_in3", eng_in3, 0);
    chk("s_rel_busy", busy, 0); chk("s_tmo", tmo_err, 0);

    // Withdrawal: req[2] drops as LAUNCH sees 100.
    req = 4'b0100;
    tick(); chk("w_grant", grant, 4'b0100);
    tick(); req = '0;
    tick(); chk("w_drv", {eng_in1, eng_in2}, 2'b00);
    tick(); chk("w_eng000", eng_st, 3'b000);
    tick(); chk("w_grant0", grant, 0); chk("w_busy0", busy, 0);
    req = 4'b1001;
    tick(); chk("w_next_pick", grant, 4'b1000);
    wait_hold(ok); chk("w_hold", ok, 1);
    done = 4'b1000; req = '0;
    tick(); done = '0;
    tick(); tick(); chk("w_rel", grant, 0);

    // Occupancy limit without done.
    req = 4'b0001;
    wait_hold(ok); chk("t_hold", ok, 1);
    repeat (15) tick();
    chk("t_pre_in3", eng_in3, 0); chk("t_pre_tmo", tmo_err, 0);
    tick(); chk("t_in3", eng_in3, 1); chk("t_tmo", tmo_err, 1);
    req = '0;
    tick(); chk("t_tmo_pulse", tmo_err, 0);
    tick(); chk("t_rel", grant, 0);

    // done on the same cycle as expiry: normal release.
    req = 4'b0001;
    wait_hold(ok); chk("d_hold", ok, 1);
    repeat (15) tick();
    done = 4'b0001;
    tick(); done = '0; req = '0;
    chk("d_in3", eng_in3, 1); chk("d_no_tmo", tmo_err, 0);
    tick(); tick(); chk("d_rel", grant, 0);

    // Engine stuck at 000 during LAUNCH.
    stall = 1'b1; req = 4'b0010;
    tick(); chk("e_grant", grant, 4'b0010); chk("e_in1", eng_in1, 1);
    repeat (15) tick();
    chk("e_pre_err", eng_err, 0); chk("e_pre_in1", eng_in1, 1);
    tick(); req = '0;
    chk("e_err", eng_err, 1); chk("e_grant0", grant, 0);
    chk("e_drv0", {eng_in1, eng_in2, eng_in3}, 0); chk("e_busy0", busy, 0);
    tick(); chk("e_err_pulse", eng_err, 0); chk("e_idle_grant", grant, 0);
    stall = 1'b0;

    // Asynchronous reset in HOLD.
    req = 4'b0100;
    wait_hold(ok); chk("r_hold", ok, 1);
    chk("r_grant", grant, 4'b0100);
    rst_n = 1'b0; req = '0;
    #1;
    chk("r_async_grant", grant, 0);
    chk("r_async_drv", {eng_in1, eng_in2, eng_in3}, 0);
    chk("r_async_busy", busy, 0);
    tick(); tick();
    rst_n = 1'b1;

    // After reset req0 wins first; re-raised req0 then waits behind req3.
    req = 4'b0001;
    tick(); chk("f_first", grant, 4'b0001);
    wait_hold(ok); chk("f_hold", ok, 1);
    done = 4'b0001; req = 4'b1001;
    tick(); done = '0;
    tick(); tick(); chk("f_rel", grant, 0);
    tick(); chk("f_fair", grant, 4'b1000);
    wait_hold(ok); chk("f_hold3", ok, 1);
    done = 4'b1000; req = 4'b0000;
    tick(); done = '0;
    tick(); tick(); chk("f_rel3", grant, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
